// File: rtl/blk_pkg.sv
// blk_pkg: shared widths, pad value and loader state encoding
package blk_pkg;
  localparam int W = 64;
  localparam int N = 8;
  localparam int SW = $clog2(N);
  localparam logic [W-1:0] PAD_VAL = '0;
  typedef enum logic [1:0] {FILL, PAD, FULL} state_t;
endpackage

// File: rtl/blk_ldr_ctr.sv
// ctr_mod: mod-N slot counter with clear and increment
module ctr_mod #(
  parameter int N = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [SW-1:0] q
);
  // clear wins over increment; increment wraps at N-1
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= (q == SW'(N - 1)) ? '0 : q + 1'b1;
endmodule

// File: rtl/blk_ldr.sv
// blk_ldr: streams words into the 8x64 register file, zero-pads short blocks, holds until ack
module blk_ldr
  import blk_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          we,
  output logic [SW-1:0] s,
  output logic [W-1:0]  d,
  output logic          blk_rdy,
  input  logic          blk_ack,
  output logic [SW:0]   nwords
);
  state_t state;
  logic [SW-1:0] cnt;
  logic acc, last_slot;
  assign acc = in_vld & in_rdy;
  assign last_slot = cnt == SW'(N - 1);
  ctr_mod #(.N(N)) u_ctr (
    .clk (clk),
    .rst (rst),
    .inc (((state == FILL) & acc & ~last_slot) | ((state == PAD) & ~last_slot)),
    .clr ((state == FULL) & blk_ack),
    .q   (cnt)
  );
  // FSM with registered write port; in_rdy is registered so it drops on the edge that ends filling
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= FILL;
      in_rdy  <= 1'b0;
      we      <= 1'b0;
      s       <= '0;
      d       <= '0;
      blk_rdy <= 1'b0;
      nwords  <= '0;
    end else begin
      case (state)
        FILL: begin
          we     <= acc;
          in_rdy <= ~(acc & (last_slot | in_last));
          if (acc) begin
            s      <= cnt;
            d      <= in_data;
            nwords <= {1'b0, cnt} + (SW + 1)'(1);
            state  <= last_slot ? FULL : (in_last ? PAD : FILL);
          end
        end
        PAD: begin
          we     <= 1'b1;
          in_rdy <= 1'b0;
          s      <= cnt;
          d      <= PAD_VAL;
          if (last_slot) state <= FULL;
        end
        FULL: begin
          we      <= 1'b0;
          blk_rdy <= ~blk_ack;
          in_rdy  <= blk_ack;
          if (blk_ack) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
endmodule

// File: tb/tb_blk_ldr.sv
// tb_blk_ldr: randomized block loads checked against a padded-block reference model
module tb_blk_ldr;
  import blk_pkg::*;
  logic clk = 0, rst = 0, in_vld = 0, in_last = 0, blk_ack = 0;
  logic [W-1:0] in_data = '0;
  logic in_rdy, we, blk_rdy;
  logic [SW-1:0] s;
  logic [W-1:0] d;
  logic [SW:0] nwords;
  int checks = 0, failures = 0;
  typedef struct {int s; logic [W-1:0] d; int cyc;} wr_t;
  wr_t wlog[$];
  logic [W-1:0] rf[N];
  int ncyc = 0, rise_cyc = -1;
  logic prev_rdy = 0;

  blk_ldr dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .in_last(in_last), .we(we), .s(s), .d(d), .blk_rdy(blk_rdy),
    .blk_ack(blk_ack), .nwords(nwords)
  );

  always #5 clk = ~clk;

  // register-file model plus write log; a write seen here is captured at the next posedge
  always @(negedge clk) begin
    ncyc++;
    if (!rst && we) begin
      wlog.push_back('{int'(s), d, ncyc});
      rf[s] = d;
    end
    if (blk_rdy && !prev_rdy) rise_cyc = ncyc;
    prev_rdy = blk_rdy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_msg(input int k, input bit gapped, input bit hold, input int ack_dly,
                          input bit abort, input bit seq);
    logic [W-1:0] w[N];
    logic [N*W-1:0] q_exp, q_got;
    int i = 0, g = 0;
    bit bad = 0;
    wlog.delete();
    rise_cyc = -1;
    for (int j = 0; j < N; j++)
      w[j] = (j < k) ? (seq ? W'(j + 1) : {$urandom, $urandom}) : PAD_VAL;
    while (i < k && g < 100) begin
      tick();
      in_vld = gapped ? (g % 2 == 0) : 1'b1;
      in_data = w[i];
      in_last = !abort && (i == k - 1);
      if (in_vld && in_rdy) i++;
      g++;
    end
    tick();
    in_vld = hold;
    in_last = 0;
    in_data = {$urandom, $urandom};
    if (abort) return;
    g = 0;
    while (!blk_rdy && g < 40) begin
      tick();
      g++;
    end
    chk("blk_rdy_rise", blk_rdy, 1);
    chk("nwords", 64'(nwords), 64'(k));
    for (int j = 0; j < ack_dly; j++) begin
      if (in_rdy !== 1'b0 || we !== 1'b0 || blk_rdy !== 1'b1) bad = 1;
      tick();
    end
    chk("full_hold", 64'(bad), 0);
    blk_ack = 1;
    tick();
    blk_ack = 0;
    in_vld = 0;
    chk("blk_rdy_after_ack", blk_rdy, 0);
    chk("in_rdy_after_ack", in_rdy, 1);
    chk("write_count", 64'(wlog.size()), 64'(N));
    if (wlog.size() == N) begin
      for (int j = 0; j < N; j++) begin
        chk($sformatf("slot_idx%0d", j), 64'(wlog[j].s), 64'(j));
        chk($sformatf("slot_data%0d", j), wlog[j].d, w[j]);
      end
      chk("rdy_after_slot7", 64'(rise_cyc - wlog[N-1].cyc), 1);
      if (k < N) chk("rdy_after_last_real", 64'(rise_cyc - (wlog[k-1].cyc + 1)), 64'(N - k));
      if (!gapped && k == N) chk("back_to_back", 64'(wlog[N-1].cyc - wlog[0].cyc), 64'(N - 1));
    end
    for (int j = 0; j < N; j++) begin
      q_exp[j*W +: W] = w[j];
      q_got[j*W +: W] = rf[j];
    end
    chk("regfile_q_lo", q_got[63:0], q_exp[63:0]);
    chk("regfile_q_hi", q_got[N*W-1 -: 64], q_exp[N*W-1 -: 64]);
    chk("regfile_q_eq", 64'(q_got == q_exp), 1);
  endtask

  initial begin
    #1 rst = 1;
    #1;
    chk("rst_we", we, 0);
    chk("rst_s", 64'(s), 0);
    chk("rst_d", d, 0);
    chk("rst_blk_rdy", blk_rdy, 0);
    chk("rst_nwords", 64'(nwords), 0);
    chk("rst_in_rdy", in_rdy, 0);
    tick();
    tick();
    rst = 0;
    tick();
    chk("in_rdy_after_release", in_rdy, 1);
    send_msg(8, 0, 0, 0, 0, 1);
    send_msg(3, 0, 0, 1, 0, 0);
    send_msg(8, 0, 1, 4, 0, 0);
    send_msg(8, 0, 0, 2, 0, 0);
    send_msg(5, 1, 0, 0, 0, 0);
    send_msg(1, 0, 0, 0, 0, 0);
    send_msg(7, 0, 0, 1, 0, 0);
    for (int r = 0; r < 6; r++)
      send_msg(int'($urandom_range(1, N)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, 0);
    send_msg(5, 0, 0, 0, 1, 0);
    tick();
    rst = 1;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_blk_rdy", blk_rdy, 0);
    chk("mid_rst_in_rdy", in_rdy, 0);
    chk("mid_rst_nwords", 64'(nwords), 0);
    tick();
    rst = 0;
    tick();
    chk("in_rdy_after_mid_rst", in_rdy, 1);
    send_msg(8, 0, 0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
